// File: rtl/pic_core_param.sv
// Parametrised 8259-style interrupt controller core: IRR/ISR/IMR, fully nested
// arbitration with optional rotating priority and a single-cycle vector handshake.
module pic_core_param #(
    parameter int unsigned NUM_IRQ = 16,
    parameter int unsigned VEC_W   = 8,
    localparam int unsigned ID_W   = $clog2(NUM_IRQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               cfg_level,
    input  logic               cfg_auto_eoi,
    input  logic               cfg_rotate,
    input  logic [VEC_W-1:0]   cfg_vector_base,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               eoi_valid,
    input  logic               eoi_specific,
    input  logic [ID_W-1:0]    eoi_id,
    input  logic               ack_req,
    output logic               int_out,
    output logic               ack_valid,
    output logic [VEC_W-1:0]   ack_vector,
    output logic [ID_W-1:0]    ack_id,
    output logic               ack_spurious,
    output logic [NUM_IRQ-1:0] irr,
    output logic [NUM_IRQ-1:0] isr,
    output logic [NUM_IRQ-1:0] imr
);

    typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

    state_t             state, state_n;
    logic [NUM_IRQ-1:0] irq_prev;
    logic [ID_W-1:0]    rot_base, rot_n;
    logic [NUM_IRQ-1:0] irr_n, isr_n;
    logic [NUM_IRQ-1:0] eligible;
    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic               isr_found;
    logic [ID_W-1:0]    isr_top;
    logic               load;
    logic               grant;

    // Walk lines in priority order starting after rot_base; stop eligibility at the first ISR bit.
    always_comb begin : arbitrate
        int unsigned hi;
        int unsigned line;
        eligible  = '0;
        isr_found = 1'b0;
        isr_top   = '0;
        win_found = 1'b0;
        win_id    = ID_W'(NUM_IRQ - 1);
        hi        = (32'(rot_base) >= NUM_IRQ - 1) ? 32'd0 : 32'(rot_base) + 32'd1;
        line      = 32'd0;
        for (int unsigned k = 0; k < NUM_IRQ; k++) begin
            line = hi + k;
            if (line >= NUM_IRQ) line = line - NUM_IRQ;
            if (!isr_found && isr[ID_W'(line)]) begin
                isr_found = 1'b1;
                isr_top   = ID_W'(line);
            end
            if (!isr_found && irr[ID_W'(line)] && !imr[ID_W'(line)]) begin
                eligible[ID_W'(line)] = 1'b1;
                if (!win_found) begin
                    win_found = 1'b1;
                    win_id    = ID_W'(line);
                end
            end
        end
    end

    // Handshake sequencing plus next IRR/ISR/rotation values; EOI clears before the grant sets.
    always_comb begin : next_state
        state_n = state;
        load    = 1'b0;
        grant   = (state == GRANT) && !ack_spurious;
        irr_n   = cfg_level ? irq_in : (irr | (irq_in & ~irq_prev));
        isr_n   = isr;
        rot_n   = rot_base;

        case (state)
            IDLE: begin
                if (ack_req) begin
                    state_n = GRANT;
                    load    = 1'b1;
                end
            end
            GRANT:   state_n = HOLD;
            HOLD:    if (!ack_req) state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (grant) irr_n[ack_id] = 1'b0;

        if (eoi_valid) begin
            if (eoi_specific) begin
                if (32'(eoi_id) < NUM_IRQ) isr_n[eoi_id] = 1'b0;
            end else if (isr_found) begin
                isr_n[isr_top] = 1'b0;
                if (cfg_rotate) rot_n = isr_top;
            end
        end

        if (grant) begin
            if (!cfg_auto_eoi) isr_n[ack_id] = 1'b1;
            else if (cfg_rotate) rot_n = ack_id;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            irr          <= '0;
            isr          <= '0;
            imr          <= '1;
            irq_prev     <= '0;
            rot_base     <= ID_W'(NUM_IRQ - 1);
            int_out      <= 1'b0;
            ack_valid    <= 1'b0;
            ack_vector   <= '0;
            ack_id       <= '0;
            ack_spurious <= 1'b0;
        end else begin
            state     <= state_n;
            irr       <= irr_n;
            isr       <= isr_n;
            rot_base  <= rot_n;
            irq_prev  <= irq_in;
            int_out   <= |eligible;
            ack_valid <= load;
            if (mask_we) imr <= mask_wdata;
            // Winner is frozen at IDLE->GRANT; later mask/request changes cannot move it.
            if (load) begin
                ack_id       <= win_id;
                ack_spurious <= !win_found;
                ack_vector   <= cfg_vector_base + VEC_W'(win_id);
            end
        end
    end

endmodule

// File: tb/tb_pic_core_param.sv
// Bench for pic_core_param: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a rank-based reference model.
module tb_pic_core_param;

    localparam int N  = 16;
    localparam int VW = 8;
    localparam int IW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  irq_in = '0;
    logic          cfg_level = 1'b0;
    logic          cfg_auto_eoi = 1'b0;
    logic          cfg_rotate = 1'b0;
    logic [VW-1:0] cfg_vector_base = 8'h40;
    logic          mask_we = 1'b0;
    logic [N-1:0]  mask_wdata = '0;
    logic          eoi_valid = 1'b0;
    logic          eoi_specific = 1'b0;
    logic [IW-1:0] eoi_id = '0;
    logic          ack_req = 1'b0;
    logic          int_out;
    logic          ack_valid;
    logic [VW-1:0] ack_vector;
    logic [IW-1:0] ack_id;
    logic          ack_spurious;
    logic [N-1:0]  irr, isr, imr;

    pic_core_param #(.NUM_IRQ(N), .VEC_W(VW)) dut (
        .clock(clock), .reset(reset), .irq_in(irq_in),
        .cfg_level(cfg_level), .cfg_auto_eoi(cfg_auto_eoi), .cfg_rotate(cfg_rotate),
        .cfg_vector_base(cfg_vector_base), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .eoi_valid(eoi_valid), .eoi_specific(eoi_specific), .eoi_id(eoi_id),
        .ack_req(ack_req), .int_out(int_out), .ack_valid(ack_valid),
        .ack_vector(ack_vector), .ack_id(ack_id), .ack_spurious(ack_spurious),
        .irr(irr), .isr(isr), .imr(imr)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [N-1:0]  m_irr, m_isr, m_imr, m_prev;
    int            m_rot, m_phase, m_aid;
    bit            m_int, m_av, m_asp;
    logic [VW-1:0] m_avec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_irr = '0; m_isr = '0; m_imr = '1; m_prev = '0;
        m_rot = N - 1; m_phase = 0; m_aid = 0;
        m_int = 0; m_av = 0; m_asp = 0; m_avec = '0;
    endtask

    // Priority rank of line i: 0 for the line right after the rotation base.
    function automatic int rank_of(input int i, input int rot);
        return (i - ((rot + 1) % N) + N) % N;
    endfunction

    task automatic model_edge();
        int top_rank, top_id, best, win, r;
        bit g;
        logic [N-1:0] n_irr, n_isr;
        int n_rot, n_phase;
        top_rank = N; top_id = 0;
        for (int i = 0; i < N; i++) begin
            r = rank_of(i, m_rot);
            if (m_isr[i] && r < top_rank) begin top_rank = r; top_id = i; end
        end
        best = N; win = N - 1;
        for (int i = 0; i < N; i++) begin
            r = rank_of(i, m_rot);
            if (m_irr[i] && !m_imr[i] && r < top_rank && r < best) begin best = r; win = i; end
        end
        g = (m_phase == 1) && !m_asp;
        n_irr = cfg_level ? irq_in : (m_irr | (irq_in & ~m_prev));
        if (g) n_irr[m_aid] = 1'b0;
        n_isr = m_isr; n_rot = m_rot;
        if (eoi_valid) begin
            if (eoi_specific) begin
                if (int'(eoi_id) < N) n_isr[eoi_id] = 1'b0;
            end else if (top_rank < N) begin
                n_isr[top_id] = 1'b0;
                if (cfg_rotate) n_rot = top_id;
            end
        end
        if (g) begin
            if (!cfg_auto_eoi) n_isr[m_aid] = 1'b1;
            else if (cfg_rotate) n_rot = m_aid;
        end
        n_phase = m_phase;
        m_av = 0;
        if (m_phase == 0 && ack_req) begin
            n_phase = 1; m_av = 1;
            m_aid = win; m_asp = (best == N);
            m_avec = VW'(int'(cfg_vector_base) + win);
        end else if (m_phase == 1) n_phase = 2;
        else if (m_phase == 2 && !ack_req) n_phase = 0;
        m_int = (best < N);
        m_prev = irq_in;
        if (mask_we) m_imr = mask_wdata;
        m_irr = n_irr; m_isr = n_isr; m_rot = n_rot; m_phase = n_phase;
    endtask

    // One clock: advance the model with the current inputs, then compare after the edge.
    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        check("int_out", 32'(int_out), 32'(m_int));
        check("ack_valid", 32'(ack_valid), 32'(m_av));
        if (m_av) begin
            check("ack_id", 32'(ack_id), 32'(m_aid));
            check("ack_vector", 32'(ack_vector), 32'(m_avec));
            check("ack_spurious", 32'(ack_spurious), 32'(m_asp));
        end
        check("irr", 32'(irr), 32'(m_irr));
        check("isr", 32'(isr), 32'(m_isr));
        check("imr", 32'(imr), 32'(m_imr));
    endtask

    task automatic idle_inputs();
        irq_in = '0; mask_we = 0; mask_wdata = '0; eoi_valid = 0;
        eoi_specific = 0; eoi_id = '0; ack_req = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_int_out"}, 32'(int_out), 32'd0);
        check({tag, "_ack_valid"}, 32'(ack_valid), 32'd0);
        check({tag, "_ack_vector"}, 32'(ack_vector), 32'd0);
        check({tag, "_ack_id"}, 32'(ack_id), 32'd0);
        check({tag, "_ack_spurious"}, 32'(ack_spurious), 32'd0);
        check({tag, "_irr"}, 32'(irr), 32'd0);
        check({tag, "_isr"}, 32'(isr), 32'd0);
        check({tag, "_imr"}, 32'(imr), 32'h0000_FFFF);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_reset_values("reset");
        reset = 0;
    endtask

    // Raise ack_req until ack_valid (bounded), then finish the handshake back to idle.
    task automatic handshake(output int id, output int sp, output int vec);
        bit seen = 0;
        id = -1; sp = -1; vec = -1;
        ack_req = 1;
        for (int i = 0; i < 4 && !seen; i++) begin
            step();
            if (ack_valid) begin
                seen = 1; id = int'(ack_id); sp = int'(ack_spurious); vec = int'(ack_vector);
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL handshake_timeout ack_valid=0 expected=1 at %0t", $time);
        end
        step();
        ack_req = 0;
        step();
    endtask

    task automatic pulse_irq(input logic [N-1:0] lines);
        irq_in = lines; step();
        irq_in = '0;    step();
    endtask

    typedef struct {
        logic [N-1:0]  irq;
        logic          mwe;
        logic [N-1:0]  mwd;
        logic          ev;
        logic          es;
        logic [IW-1:0] eid;
        logic          ack;
        logic          x_int;
        logic          x_av;
        logic [IW-1:0] x_id;
        logic [N-1:0]  x_isr;
        logic [N-1:0]  x_irr;
    } vec_t;

    vec_t tbl[19];

    initial begin
        int id, sp, vec, pend_cycles;
        bit pending;

        // Edge mode, fixed priority, base 0x40: single grant, then nested 3-over-9.
        tbl[0]  = '{16'h0000, 1, 16'h0000, 0, 0, 4'd0, 0,  0, 0, 4'd0, 16'h0000, 16'h0000};
        tbl[1]  = '{16'h0020, 0, 16'h0000, 0, 0, 4'd0, 0,  0, 0, 4'd0, 16'h0000, 16'h0020};
        tbl[2]  = '{16'h0000, 0, 16'h0000, 0, 0, 4'd0, 0,  1, 0, 4'd0, 16'h0000, 16'h0020};
        tbl[3]  = '{16'h0000, 0, 16'h0000, 0, 0, 4'd0, 1,  1, 1, 4'd5, 16'h0000, 16'h0020};
        tbl[4]  = '{16'h0000, 0, 16'h0000, 0, 0, 4'd0, 1,  1, 0, 4'd0, 16'h0020, 16'h0000};
        tbl[5]  = '{16'h0000, 0, 16'h0000, 0, 0, 4'd0, 0,  0, 0, 4'd0, 16'h0020, 16'h0000};
        tbl[6]  = '{16'h0208, 0, 16'h0000, 0, 0, 4'd0, 0,  0, 0, 4'd0, 16'h0020, 16'h0208};
        tbl[7]  = '{16'h0208, 0, 16'h0000, 0, 0, 4'd0, 0,  1, 0, 4'd0, 16'h0020, 16'h0208};
        tbl[8]  = '{16'h0000, 0, 16'h0000, 0, 0, 4'd0, 1,  1, 1, 4'd3, 16'h0020, 16'h0208};
        tbl[9]  = '{16'h0000, 0, 16'h0000, 0, 0, 4'd0, 1,  1, 0, 4'd0, 16'h0028, 16'h0200};
        tbl[10] = '{16'h0000, 0, 16'h0000, 0, 0, 4'd0, 0,  0, 0, 4'd0, 16'h0028, 16'h0200};
        tbl[11] = '{16'h0000, 0, 16'h0000, 1, 0, 4'd0, 0,  0, 0, 4'd0, 16'h0020, 16'h0200};
        tbl[12] = '{16'h0000, 0, 16'h0000, 0, 0, 4'd0, 0,  0, 0, 4'd0, 16'h0020, 16'h0200};
        tbl[13] = '{16'h0000, 0, 16'h0000, 1, 0, 4'd0, 0,  0, 0, 4'd0, 16'h0000, 16'h0200};
        tbl[14] = '{16'h0000, 0, 16'h0000, 0, 0, 4'd0, 0,  1, 0, 4'd0, 16'h0000, 16'h0200};
        tbl[15] = '{16'h0000, 0, 16'h0000, 0, 0, 4'd0, 1,  1, 1, 4'd9, 16'h0000, 16'h0200};
        tbl[16] = '{16'h0000, 0, 16'h0000, 0, 0, 4'd0, 1,  1, 0, 4'd0, 16'h0200, 16'h0000};
        tbl[17] = '{16'h0000, 0, 16'h0000, 0, 0, 4'd0, 0,  0, 0, 4'd0, 16'h0200, 16'h0000};
        tbl[18] = '{16'h0000, 0, 16'h0000, 1, 1, 4'd9, 0,  0, 0, 4'd0, 16'h0000, 16'h0000};

        do_reset();
        for (int v = 0; v < 19; v++) begin
            irq_in = tbl[v].irq; mask_we = tbl[v].mwe; mask_wdata = tbl[v].mwd;
            eoi_valid = tbl[v].ev; eoi_specific = tbl[v].es; eoi_id = tbl[v].eid;
            ack_req = tbl[v].ack;
            step();
            check($sformatf("tbl%0d_int_out", v), 32'(int_out), 32'(tbl[v].x_int));
            check($sformatf("tbl%0d_ack_valid", v), 32'(ack_valid), 32'(tbl[v].x_av));
            if (tbl[v].x_av) begin
                check($sformatf("tbl%0d_ack_id", v), 32'(ack_id), 32'(tbl[v].x_id));
                check($sformatf("tbl%0d_ack_vector", v), 32'(ack_vector), 32'h40 + 32'(tbl[v].x_id));
            end
            check($sformatf("tbl%0d_isr", v), 32'(isr), 32'(tbl[v].x_isr));
            check($sformatf("tbl%0d_irr", v), 32'(irr), 32'(tbl[v].x_irr));
        end
        idle_inputs();

        // Rotation: non-specific EOI of line 2 makes line 3 highest priority.
        do_reset();
        cfg_rotate = 1;
        mask_we = 1; mask_wdata = '0; step(); mask_we = 0;
        pulse_irq(16'h0004); step();
        handshake(id, sp, vec);
        check("rot_first_id", 32'(id), 32'd2);
        eoi_valid = 1; step(); eoi_valid = 0;
        pulse_irq(16'h0009); step();
        handshake(id, sp, vec);
        check("rot_second_id", 32'(id), 32'd3);
        cfg_rotate = 0;

        // Masking after int_out rose yields a spurious grant that leaves irr/isr alone.
        do_reset();
        mask_we = 1; mask_wdata = '0; step(); mask_we = 0;
        pulse_irq(16'h0010);
        check("spur_int_before_mask", 32'(int_out), 32'd1);
        mask_we = 1; mask_wdata = 16'h0010; step(); mask_we = 0;
        handshake(id, sp, vec);
        check("spur_flag", 32'(sp), 32'd1);
        check("spur_id", 32'(id), 32'(N - 1));
        check("spur_isr", 32'(isr), 32'd0);
        check("spur_irr", 32'(irr), 32'h0010);

        // Auto-EOI with vector base wrap.
        do_reset();
        cfg_auto_eoi = 1; cfg_vector_base = 8'hFE;
        mask_we = 1; mask_wdata = '0; step(); mask_we = 0;
        pulse_irq(16'h0010); step();
        handshake(id, sp, vec);
        check("aeoi_id", 32'(id), 32'd4);
        check("aeoi_vector", 32'(vec), 32'h02);
        check("aeoi_isr", 32'(isr), 32'd0);
        cfg_auto_eoi = 0; cfg_vector_base = 8'h40;

        // Asynchronous reset while the handshake sits in HOLD.
        do_reset();
        mask_we = 1; mask_wdata = '0; step(); mask_we = 0;
        pulse_irq(16'h0100); step();
        ack_req = 1; step(); step();
        check("hold_isr", 32'(isr), 32'h0100);
        #3 reset = 1;
        #1 check_reset_values("async");
        ack_req = 0;
        model_reset();
        @(negedge clock);
        reset = 0;

        // Randomized traffic against the model.
        pending = 0; pend_cycles = 0;
        for (int c = 0; c < 2000; c++) begin
            if (c % 250 == 0) begin
                cfg_level = 1'($urandom); cfg_auto_eoi = 1'($urandom);
                cfg_rotate = 1'($urandom); cfg_vector_base = 8'($urandom);
            end
            irq_in = ($urandom % 3 == 0) ? 16'($urandom & $urandom & $urandom) : '0;
            mask_we = ($urandom % 16 == 0);
            mask_wdata = 16'($urandom & $urandom & $urandom);
            eoi_valid = ($urandom % 5 == 0);
            eoi_specific = 1'($urandom);
            eoi_id = 4'($urandom);
            if (ack_valid) pending = 0;
            else if (!pending && m_phase == 0 && $urandom % 4 == 0) pending = 1;
            if (pending) pend_cycles++; else pend_cycles = 0;
            if (pend_cycles > 4) begin
                checks++; errors++;
                $display("FAIL ack_timeout ack_valid=0 expected=1 at %0t", $time);
                pending = 0; pend_cycles = 0;
            end
            ack_req = pending;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
